// File: rtl/hs4_tx_bridge.sv
// Clocked valid/ready producer to 4-phase bundled-data req/ack bridge.
// Words are buffered in a small FIFO; the asynchronous ack is synchronised before use.
module hs4_tx_bridge #(
    parameter int WD          = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WD-1:0]              in_data,
    output logic                       out_req,
    output logic [WD-1:0]              out_data,
    input  logic                       out_ack,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_HI = 2'd1,
        ST_REQ_LO = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_s;
    logic                   ack_prev_q, ack_prev_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [WD-1:0]          mem_q [DEPTH];
    logic [WD-1:0]          mem_d [DEPTH];
    logic                   out_req_q, out_req_d;
    logic [WD-1:0]          out_data_q, out_data_d;
    logic                   proto_err_q, proto_err_d;
    logic                   push_s, pop_s, not_empty_s;

    assign ack_s       = sync_q[SYNC_STAGES-1];
    assign not_empty_s = (count_q != CW'(0));
    assign in_ready    = (count_q != CW'(DEPTH));
    assign push_s      = in_valid && in_ready;
    assign out_req     = out_req_q;
    assign out_data    = out_data_q;
    assign fill_level  = count_q;
    assign proto_err   = proto_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (not_empty_s) state_d = ST_REQ_HI; else state_d = ST_IDLE;
            ST_REQ_HI: if (ack_s)       state_d = ST_REQ_LO; else state_d = ST_REQ_HI;
            ST_REQ_LO: if (!ack_s)      state_d = ST_IDLE;   else state_d = ST_REQ_LO;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Launch of a new word: the head is popped and latched together with the req rise.
    always_comb begin
        pop_s      = 1'b0;
        out_req_d  = out_req_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (not_empty_s) begin
                    pop_s      = 1'b1;
                    out_req_d  = 1'b1;
                    out_data_d = mem_q[rd_ptr_q];
                end else begin
                    out_req_d  = 1'b0;
                end
            end
            ST_REQ_HI: if (ack_s) out_req_d = 1'b0; else out_req_d = 1'b1;
            ST_REQ_LO: out_req_d = 1'b0;
            default:   out_req_d = 1'b0;
        endcase
    end

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], out_ack};
        ack_prev_d = ack_s;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Sticky: ack seen while idle, or ack dropping before req was released.
        proto_err_d = proto_err_q
                   || ((state_q == ST_IDLE) && ack_s)
                   || ((state_q == ST_REQ_HI) && ack_prev_q && !ack_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= {SYNC_STAGES{1'b0}};
            ack_prev_q  <= 1'b0;
            mem_q       <= '{default: {WD{1'b0}}};
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            out_req_q   <= 1'b0;
            out_data_q  <= {WD{1'b0}};
            proto_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            ack_prev_q  <= ack_prev_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_req_q   <= out_req_d;
            out_data_q  <= out_data_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule
